// File: rtl/sync_detector.sv
// Horizontal sync detector: measures line period and sync width,
// and declares lock after a run of identical lines.
module sync_detector #(
  parameter int N          = 7,
  parameter int LOCK_LINES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync_in,
  output logic [N:0] count,
  output logic [N:0] period,
  output logic [N:0] width,
  output logic       line_strobe,
  output logic       locked
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TRACK,
    LOCKED
  } state_t;

  localparam logic [3:0] LOCK_M = 4'(LOCK_LINES);

  state_t       state, state_nx;
  logic         prev;
  logic         fall, rise, sat, hit;
  logic [N+1:0] meas;
  logic [N:0]   pend, pend_nx;
  logic [N:0]   ref_p, ref_p_nx;
  logic [N:0]   ref_w, ref_w_nx;
  logic [N:0]   period_nx, width_nx;
  logic [3:0]   match, match_nx;
  logic         strobe_nx;

  assign fall = prev & ~hsync_in;
  assign rise = ~prev & hsync_in;
  assign meas = {1'b0, count} + {{(N+1){1'b0}}, 1'b1};
  // carry out of count+1 means count sits at all ones
  assign sat  = meas[N+1];
  assign hit  = (meas[N:0] == ref_p) && (pend == ref_w);

  always_comb begin
    state_nx  = state;
    match_nx  = match;
    pend_nx   = pend;
    ref_p_nx  = ref_p;
    ref_w_nx  = ref_w;
    period_nx = period;
    width_nx  = width;
    strobe_nx = 1'b0;
    if (sat) begin
      match_nx = '0;
      state_nx = fall ? MEASURE : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (fall) state_nx = MEASURE;
        end
        default: begin
          if (rise) pend_nx = meas[N:0];
          if (fall) begin
            period_nx = meas[N:0];
            width_nx  = pend;
            strobe_nx = 1'b1;
            if (state != MEASURE && hit) begin
              if (match >= LOCK_M - 4'd1) begin
                match_nx = LOCK_M;
                state_nx = LOCKED;
              end else begin
                match_nx = match + 4'd1;
                state_nx = TRACK;
              end
            end else begin
              ref_p_nx = meas[N:0];
              ref_w_nx = pend;
              match_nx = '0;
              state_nx = TRACK;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      prev        <= 1'b0;
      count       <= '0;
      period      <= '0;
      width       <= '0;
      pend        <= '0;
      ref_p       <= '0;
      ref_w       <= '0;
      match       <= '0;
      line_strobe <= 1'b0;
    end else begin
      state       <= state_nx;
      prev        <= hsync_in;
      period      <= period_nx;
      width       <= width_nx;
      pend        <= pend_nx;
      ref_p       <= ref_p_nx;
      ref_w       <= ref_w_nx;
      match       <= match_nx;
      line_strobe <= strobe_nx;
      if (fall)
        count <= '0;
      else if (!sat)
        count <= meas[N:0];
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_sync_detector.sv
// Scoreboard bench for sync_detector: timestamp-based reference model,
// per-cycle expectations queued by the driver, popped by a monitor.
module tb_sync_detector;

  localparam int N    = 7;
  localparam int LOCK = 3;
  localparam int MAXC = (1 << (N + 1)) - 1;

  logic       clk;
  logic       rst;
  logic       hsync_in;
  logic [N:0] count;
  logic [N:0] period;
  logic [N:0] width;
  logic       line_strobe;
  logic       locked;

  sync_detector #(.N(N), .LOCK_LINES(LOCK)) dut (
    .clk(clk),
    .rst(rst),
    .hsync_in(hsync_in),
    .count(count),
    .period(period),
    .width(width),
    .line_strobe(line_strobe),
    .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int c;
    int p;
    int w;
    bit s;
    bit l;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // reference model: cycle stamps of the last fall (or reset) and
  // the list of lines measured since the detector last (re)armed
  int   t = 0;
  int   anchor = 0;
  bit   mprev = 0;
  bit   armed = 0;
  int   pend = 0;
  int   per = 0;
  int   wid = 0;
  int   hp[$];
  int   hw[$];

  function automatic bit is_locked();
    int n;
    n = hp.size();
    if (n < LOCK + 1) return 1'b0;
    for (int i = n - LOCK - 1; i < n; i++)
      if (hp[i] != hp[n-1] || hw[i] != hw[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input bit r, input bit h);
    exp_t e;
    bit   fall, rise;
    int   c_in;
    t++;
    e.s = 1'b0;
    if (!r) begin
      anchor = t;
      mprev  = 1'b0;
      armed  = 1'b0;
      pend   = 0;
      per    = 0;
      wid    = 0;
      hp.delete();
      hw.delete();
      e.c = 0;
      e.p = 0;
      e.w = 0;
      e.l = 1'b0;
    end else begin
      fall = mprev && !h;
      rise = !mprev && h;
      c_in = t - 1 - anchor;
      if (c_in > MAXC) c_in = MAXC;
      if (c_in == MAXC) begin
        armed = fall;
        hp.delete();
        hw.delete();
      end else if (!armed) begin
        armed = fall;
      end else begin
        if (rise) pend = t - anchor;
        if (fall) begin
          per = t - anchor;
          wid = pend;
          e.s = 1'b1;
          hp.push_back(per);
          hw.push_back(wid);
          if (hp.size() > LOCK + 1) begin
            void'(hp.pop_front());
            void'(hw.pop_front());
          end
        end
      end
      if (fall) anchor = t;
      e.c = (t - anchor > MAXC) ? MAXC : t - anchor;
      e.p = per;
      e.w = wid;
      e.l = is_locked();
      mprev = h;
    end
    expq.push_back(e);
  endtask

  task automatic drive(input bit r, input bit h);
    @(negedge clk);
    rst      = r;
    hsync_in = h;
    model_step(r, h);
  endtask

  task automatic line(input int lo, input int hi);
    for (int i = 0; i < lo; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < hi; i++) drive(1'b1, 1'b1);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("count", 32'(count), 32'(e.c));
        chk("period", 32'(period), 32'(e.p));
        chk("width", 32'(width), 32'(e.w));
        chk("strobe", 32'(line_strobe), 32'(e.s));
        chk("locked", 32'(locked), 32'(e.l));
      end
    end
  end

  initial begin
    int lo, hi, reps;
    rst      = 1'b0;
    hsync_in = 1'b0;
    // reset with hsync toggling
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    // 12 low / 88 high lines until locked
    for (int i = 0; i < 8; i++) line(12, 88);
    // one long line, then recovery
    line(12, 89);
    for (int i = 0; i < 6; i++) line(12, 88);
    // long high stretch saturates the counter
    for (int i = 0; i < 300; i++) drive(1'b1, 1'b1);
    line(12, 88);
    line(12, 88);
    // relock, then reset while locked with hsync low at release
    for (int i = 0; i < 5; i++) line(12, 88);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
    drive(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) line(12, 88);
    // fastest legal toggling
    for (int i = 0; i < 10; i++) line(1, 1);
    // randomized line groups
    for (int g = 0; g < 40; g++) begin
      lo   = $urandom_range(1, 20);
      hi   = ($urandom_range(0, 9) == 0) ? $urandom_range(240, 300)
                                         : $urandom_range(1, 60);
      reps = $urandom_range(1, 6);
      for (int r = 0; r < reps; r++) line(lo, hi);
      if ($urandom_range(0, 12) == 0) begin
        drive(1'b0, 1'($urandom_range(0, 1)));
        drive(1'b1, 1'($urandom_range(0, 1)));
      end
    end
    drive(1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    chk("drain", 32'(expq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
